// File: rtl/debounce_explicit_fsm.sv
// Switch debouncer: 2-flop synchronizer feeding an explicit 4-state FSM with an
// N-bit down-counter; level is Moore-decoded, the rising-edge tick is Mealy.
module debounce_explicit_fsm #(
  parameter int N = 21
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sw,
  output logic db_level,
  output logic db_tick
);

  typedef enum logic [1:0] {
    ZERO  = 2'd0,
    WAIT1 = 2'd1,
    ONE   = 2'd2,
    WAIT0 = 2'd3
  } state_e;

  state_e         state_q, state_d;
  logic [N-1:0]   cnt_q, cnt_d;
  logic [1:0]     sync_q;
  logic           sw_s;
  logic           cnt_zero;

  assign sw_s     = sync_q[1];
  assign cnt_zero = (cnt_q == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= 2'b00;
      state_q <= ZERO;
      cnt_q   <= '0;
    end else begin
      sync_q  <= {sync_q[0], sw};
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Every WAIT state leaves at cnt_q==0, so the decrement can never wrap.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ZERO: begin
        if (sw_s) begin
          cnt_d   = '1;
          state_d = WAIT1;
        end
      end
      WAIT1: begin
        if (!sw_s)         state_d = ZERO;
        else if (cnt_zero) state_d = ONE;
        else               cnt_d   = cnt_q - 1'b1;
      end
      ONE: begin
        if (!sw_s) begin
          cnt_d   = '1;
          state_d = WAIT0;
        end
      end
      WAIT0: begin
        if (sw_s)          state_d = ONE;
        else if (cnt_zero) state_d = ZERO;
        else               cnt_d   = cnt_q - 1'b1;
      end
      default: state_d = ZERO;
    endcase
  end

  always_comb begin
    db_level = (state_q == ONE) || (state_q == WAIT0);
    db_tick  = (state_q == WAIT1) && sw_s && cnt_zero;
  end

endmodule

// File: tb/tb_debounce_explicit_fsm.sv
// Randomized and directed bench for debounce_explicit_fsm (N=4) against a
// run-length model: the level flips once the synchronized input disagrees for 2^N+1 samples.
module tb_debounce_explicit_fsm;
  localparam int N    = 4;
  localparam int HOLD = 1 << N;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sw = 1'b0;
  logic db_level, db_tick;
  int   checks = 0;
  int   errors = 0;

  // reference model state
  logic m_s1, m_s2, m_level;
  int   m_run;

  debounce_explicit_fsm #(.N(N)) dut (
    .clk(clk), .rst_n(rst_n), .sw(sw), .db_level(db_level), .db_tick(db_tick)
  );

  always #5 clk = ~clk;

  function automatic logic m_tick();
    return !m_level && m_s2 && (m_run == HOLD);
  endfunction

  task automatic m_clear();
    m_s1 = 1'b0; m_s2 = 1'b0; m_level = 1'b0; m_run = 0;
  endtask

  // Drive sw for one cycle (called at a falling edge), advance the model at the
  // rising edge, return at the next falling edge where outputs are stable.
  task automatic step(input logic v);
    sw = v;
    @(posedge clk);
    if (m_s2 != m_level) begin
      m_run++;
      if (m_run == HOLD + 1) begin
        m_level = ~m_level;
        m_run   = 0;
      end
    end else begin
      m_run = 0;
    end
    m_s2 = m_s1;
    m_s1 = v;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    sw    = 1'b0;
    m_clear();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    sw    = 1'b1;
    m_clear();
    repeat (3) @(negedge clk);
    checks++;
    if (db_level !== 1'b0 || db_tick !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: level=%b tick=%b required 0 0", db_level, db_tick);
    end
    sw    = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic test_press_hold();
    int ticks = 0;
    for (int i = 0; i <= 40; i++) begin
      step(1'b1);
      if (db_tick === 1'b1) ticks++;
      checks++;
      if (db_level !== (i >= HOLD + 2) || db_tick !== (i == HOLD + 1)) begin
        errors++;
        $display("FAIL press_hold_edge E%0d: level=%b tick=%b required level=%b tick=%b",
                 i, db_level, db_tick, (i >= HOLD + 2), (i == HOLD + 1));
      end
      checks++;
      if (db_level !== m_level || db_tick !== m_tick()) begin
        errors++;
        $display("FAIL press_hold_model E%0d: level=%b tick=%b required %b %b",
                 i, db_level, db_tick, m_level, m_tick());
      end
    end
    checks++;
    if (ticks != 1) begin
      errors++;
      $display("FAIL press_hold_ticks: got %0d required 1", ticks);
    end
  endtask

  task automatic test_bounce();
    do_reset();
    for (int i = 0; i < 30; i++) begin
      step(i < 10);
      checks++;
      if (db_level !== 1'b0 || db_tick !== 1'b0 || db_level !== m_level || db_tick !== m_tick()) begin
        errors++;
        $display("FAIL bounce E%0d: level=%b tick=%b required 0 0", i, db_level, db_tick);
      end
    end
  endtask

  task automatic test_release_glitch();
    do_reset();
    repeat (HOLD + 4) step(1'b1);
    for (int i = 0; i < 30; i++) begin
      step(i >= 5);
      checks++;
      if (db_level !== 1'b1 || db_tick !== 1'b0 || db_level !== m_level || db_tick !== m_tick()) begin
        errors++;
        $display("FAIL release_glitch E%0d: level=%b tick=%b required 1 0", i, db_level, db_tick);
      end
    end
  endtask

  task automatic test_release_hold();
    do_reset();
    repeat (HOLD + 4) step(1'b1);
    for (int i = 0; i <= 30; i++) begin
      step(1'b0);
      checks++;
      if (db_level !== (i < HOLD + 2) || db_tick !== 1'b0 || db_level !== m_level) begin
        errors++;
        $display("FAIL release_hold E%0d: level=%b tick=%b required level=%b tick=0",
                 i, db_level, db_tick, (i < HOLD + 2));
      end
    end
  endtask

  task automatic test_reset_midcount();
    int tick_at = -1;
    do_reset();
    for (int i = 0; i < 10; i++) step(1'b1);
    #2 rst_n = 1'b0;
    m_clear();
    #1;
    checks++;
    if (db_level !== 1'b0 || db_tick !== 1'b0) begin
      errors++;
      $display("FAIL reset_wait1_async: level=%b tick=%b required 0 0", db_level, db_tick);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 25; i++) begin
      step(1'b1);
      if (db_tick === 1'b1 && tick_at < 0) tick_at = i;
      checks++;
      if (db_level !== m_level || db_tick !== m_tick()) begin
        errors++;
        $display("FAIL reset_resume E%0d: level=%b tick=%b required %b %b",
                 i, db_level, db_tick, m_level, m_tick());
      end
    end
    checks++;
    if (tick_at != HOLD + 1) begin
      errors++;
      $display("FAIL reset_resume_latency: tick after edge %0d required %0d", tick_at, HOLD + 1);
    end
    // abort a release count from WAIT0: level must drop without a clock edge
    for (int i = 0; i < 8; i++) step(1'b0);
    checks++;
    if (db_level !== 1'b1) begin
      errors++;
      $display("FAIL wait0_before_reset: level=%b required 1", db_level);
    end
    #2 rst_n = 1'b0;
    m_clear();
    #1;
    checks++;
    if (db_level !== 1'b0 || db_tick !== 1'b0) begin
      errors++;
      $display("FAIL reset_wait0_async: level=%b tick=%b required 0 0", db_level, db_tick);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_back_to_back();
    int   ticks = 0;
    logic prev  = 1'b0;
    do_reset();
    for (int i = 0; i < 100; i++) begin
      step(((i / 25) % 2) == 0);
      if (db_tick === 1'b1) ticks++;
      checks++;
      if (db_level !== m_level || db_tick !== m_tick() || (prev && db_tick)) begin
        errors++;
        $display("FAIL back_to_back E%0d: level=%b tick=%b required %b %b",
                 i, db_level, db_tick, m_level, m_tick());
      end
      prev = db_tick;
    end
    checks++;
    if (ticks != 2) begin
      errors++;
      $display("FAIL back_to_back_ticks: got %0d required 2", ticks);
    end
  endtask

  task automatic test_random();
    int   left = 0;
    logic v    = 1'b0;
    logic prev = 1'b0;
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      if (left == 0) begin
        v    = 1'($urandom_range(0, 1));
        left = $urandom_range(1, 24);
      end
      left--;
      step(v);
      checks++;
      if (db_level !== m_level || db_tick !== m_tick() || (prev && db_tick)) begin
        errors++;
        $display("FAIL random E%0d: level=%b tick=%b required %b %b",
                 i, db_level, db_tick, m_level, m_tick());
      end
      prev = db_tick;
    end
  endtask

  initial begin
    m_clear();
    test_reset();
    test_press_hold();
    test_bounce();
    test_release_glitch();
    test_release_hold();
    test_reset_midcount();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
